// File: rtl/geiger_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : geiger_pkg                                                   |
// | Description : Shared constants and types for the Geiger-counter RNG:       |
// |               byte width, transmit FSM state encoding, busy-wait timeout.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package geiger_pkg;

  // Width of one transmitted byte
  localparam int BYTE_W = 8;

  // Cycles the transmitter waits for uart_tx to raise its busy flag
  localparam int WAIT_BUSY_TIMEOUT = 4;
  localparam int TO_W              = 3;

  // Transmit handshake states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage : geiger_pkg
`default_nettype wire

// File: rtl/rng_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rng_fifo                                                     |
// | Description : Synchronous byte FIFO with occupancy count. A push while     |
// |               full is accepted only if a pop happens in the same cycle;    |
// |               otherwise it is dropped and flagged on drop_o.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rng_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             w_wr_en;
  logic             w_rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign w_rd_en = pop_i && !empty_o;
  assign w_wr_en = push_i && (!full_o || w_rd_en);
  assign drop_o  = push_i && !w_wr_en;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array: written only on an accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Next pointer/occupancy; power-of-two depth lets pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_wr_en, w_rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule : rng_fifo
`default_nettype wire

// File: rtl/geiger_rng.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : geiger_rng                                                   |
// | Description : Geiger-counter random byte source. Synchronises the detector |
// |               pulse, filters it with a dead time, samples free-running     |
// |               counter LSBs per accepted event, packs bits into bytes,      |
// |               buffers them and streams them to uart_tx.                    |
// |               Optional: VON_NEUMANN_EN enables Von Neumann debiasing of    |
// |               harvested bits before they reach the byte assembler.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module geiger_rng
  import geiger_pkg::*;
#(
  parameter int CNT_WIDTH      = 8,
  parameter int BITS_PER_EVENT = 1,
  parameter int FIFO_DEPTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int DEADTIME       = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pulse_in,
  input  logic                        tx_busy,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_data_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        event_led
);

  // Assembler input carries up to 4 bits; accumulator holds 7 leftovers + 4 new
  localparam int IN_W  = 4;
  localparam int ACC_W = BYTE_W + IN_W;

  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      prev_q;
  logic                      w_edge;
  logic                      w_accept;
  logic [BITS_PER_EVENT-1:0] w_harvest;
  logic [IN_W-1:0]           w_in_bits;
  logic [2:0]                w_in_n;

  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [3:0]                acc_n_q, acc_n_d;
  logic [BYTE_W-1:0]         byte_q, byte_d;
  logic                      push_q, push_d;
  logic [3:0]                w_sum;
  logic [ACC_W-1:0]          w_shift;
  logic [ACC_W-1:0]          w_extract;

  logic                      led_q;
  logic                      overflow_q;

  logic [BYTE_W-1:0]         w_head;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic                      w_drop;
  logic                      w_pop;

  tx_state_e                 state_q, state_d;
  logic [TO_W-1:0]           wait_cnt_q, wait_cnt_d;
  logic [BYTE_W-1:0]         tx_data_q, tx_data_d;

  logic                      w_unused;

  // Free-running sample counter and pulse synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + CNT_WIDTH'(1);
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign w_edge    = sync_q[SYNC_STAGES-1] && !prev_q;
  assign w_harvest = cnt_q[BITS_PER_EVENT-1:0];

  generate
    if (DEADTIME > 0) begin : g_deadtime
      localparam int DT_W = $clog2(DEADTIME + 1);
      logic [DT_W-1:0] timer_q, timer_d;

      // An edge in the cycle the timer still reads 1 is ignored; it must read 0
      assign w_accept = w_edge && (timer_q == '0);

      // Reload on accept, otherwise count down to zero
      always_comb begin
        timer_d = timer_q;
        if (w_accept) begin
          timer_d = DT_W'(DEADTIME);
        end else if (timer_q != '0) begin
          timer_d = timer_q - DT_W'(1);
        end
      end

      // Dead-time timer register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          timer_q <= '0;
        end else begin
          timer_q <= timer_d;
        end
      end
    end else begin : g_no_deadtime
      assign w_accept = w_edge;
    end
  endgenerate

`ifdef VON_NEUMANN_EN
  logic vn_pend_q, vn_pend_d;
  logic vn_bit_q,  vn_bit_d;

  // Pair bits MSB-first with any held bit; 01 -> 0, 10 -> 1, equal pairs vanish
  always_comb begin
    vn_pend_d = vn_pend_q;
    vn_bit_d  = vn_bit_q;
    w_in_bits = '0;
    w_in_n    = '0;
    for (int i = BITS_PER_EVENT - 1; i >= 0; i--) begin
      if (vn_pend_d) begin
        if (vn_bit_d != w_harvest[i]) begin
          w_in_bits = {w_in_bits[IN_W-2:0], vn_bit_d};
          w_in_n    = w_in_n + 3'd1;
        end
        vn_pend_d = 1'b0;
      end else begin
        vn_pend_d = 1'b1;
        vn_bit_d  = w_harvest[i];
      end
    end
  end

  // Held odd bit survives until the next accepted event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_pend_q <= 1'b0;
      vn_bit_q  <= 1'b0;
    end else if (w_accept) begin
      vn_pend_q <= vn_pend_d;
      vn_bit_q  <= vn_bit_d;
    end
  end
`else
  assign w_in_bits = IN_W'(w_harvest);
  assign w_in_n    = 3'(BITS_PER_EVENT);
`endif

  // Valid bits sit right-aligned in acc_q; older bits are more significant
  assign w_sum     = acc_n_q + {1'b0, w_in_n};
  assign w_shift   = (acc_q << w_in_n) | ACC_W'(w_in_bits);
  assign w_extract = w_shift >> (w_sum - 4'd8);

  // Shift new bits in; once 8 are held, peel off the oldest 8 as a byte
  always_comb begin
    acc_d   = acc_q;
    acc_n_d = acc_n_q;
    byte_d  = byte_q;
    push_d  = 1'b0;
    if (w_accept) begin
      acc_d = w_shift;
      if (w_sum >= 4'd8) begin
        acc_n_d = w_sum - 4'd8;
        byte_d  = w_extract[BYTE_W-1:0];
        push_d  = 1'b1;
      end else begin
        acc_n_d = w_sum;
      end
    end
  end

  // Assembler, pending byte, activity LED and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      acc_n_q    <= '0;
      byte_q     <= '0;
      push_q     <= 1'b0;
      led_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_n_q    <= acc_n_d;
      byte_q     <= byte_d;
      push_q     <= push_d;
      led_q      <= led_q ^ w_accept;
      overflow_q <= overflow_q | w_drop;
    end
  end

  rng_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .din_i   (byte_q),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .level_o (fifo_level),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .drop_o  (w_drop)
  );

  // Transmit handshake: issue one byte, then follow uart_tx busy flag
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tx_data_d  = tx_data_q;
    w_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_fifo_empty && !tx_busy) begin
          state_d   = ISSUE;
          tx_data_d = w_head;
        end
      end
      ISSUE: begin
        w_pop      = 1'b1;
        wait_cnt_d = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (wait_cnt_q == TO_W'(WAIT_BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit FSM state, busy-wait counter and held output byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = (state_q == ISSUE);
  assign overflow      = overflow_q;
  assign event_led     = led_q;

  // Counter high bits and spare status feed nothing else
  assign w_unused = ^{cnt_q, w_fifo_full, w_extract[ACC_W-1:BYTE_W]};

endmodule : geiger_rng
`default_nettype wire

// File: tb/tb_geiger_rng.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_geiger_rng                                                |
// | Description : Directed self-checking bench for geiger_rng. Main instance:  |
// |               1 bit/event, dead time 20, 4-entry FIFO. Second instance:    |
// |               3 bits/event, no dead time, for byte-straddling harvest.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_geiger_rng;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse, pulse3;
  logic       busy;
  logic       busy3 = 1'b0;
  logic [7:0] data, data3;
  logic       valid, valid3;
  logic [2:0] level;
  logic [4:0] level3;
  logic       ovf, ovf3, led, led3;

  always #5 clk = ~clk;

  geiger_rng #(
    .CNT_WIDTH(8), .BITS_PER_EVENT(1), .FIFO_DEPTH(4), .SYNC_STAGES(2), .DEADTIME(20)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse), .tx_busy(busy),
    .tx_data(data), .tx_data_valid(valid), .fifo_level(level),
    .overflow(ovf), .event_led(led)
  );

  geiger_rng #(
    .CNT_WIDTH(8), .BITS_PER_EVENT(3), .FIFO_DEPTH(16), .SYNC_STAGES(2), .DEADTIME(0)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse3), .tx_busy(busy3),
    .tx_data(data3), .tx_data_valid(valid3), .fifo_level(level3),
    .overflow(ovf3), .event_led(led3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference copy of the sample counter: cleared by reset, +1 per clock
  logic [7:0] mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 8'd0;
    else        mcnt <= mcnt + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: 0 = busy for 10 cycles after a strobe, 1 = never busy, 2 = stuck busy
  int uart_mode = 0;
  int busy_cnt  = 0;
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) busy_cnt--;
      if (valid && uart_mode == 0) busy_cnt = 10;
      busy = (uart_mode == 2) || (busy_cnt != 0);
    end
  end

  // Strobe / LED monitors
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] rx3_q[$];
  int         dbl = 0;
  int         toggles = 0;
  logic       vprev = 1'b0;
  logic       ledprev = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      rx_q.push_back(data);
      rx_cyc.push_back(cyc);
    end
    if (valid && vprev) dbl++;
    vprev = valid;
    if (valid3) rx3_q.push_back(data3);
    if (led != ledprev) toggles++;
    ledprev = led;
  end

  // Pulse so that the main instance samples counter LSB = b
  task automatic send_main(input logic b);
    logic [7:0] t;
    repeat (26) @(negedge clk);
    t = mcnt + 8'd2;
    while (t[0] != b) begin
      @(negedge clk);
      t = mcnt + 8'd2;
    end
    pulse = 1'b1;
    repeat (2) @(negedge clk);
    pulse = 1'b0;
  endtask

  // Deliver one bit to the main assembler (as a 01/10 pair when debiasing)
  task automatic send_vbit(input logic b);
`ifdef VON_NEUMANN_EN
    send_main(b);
    send_main(!b);
`else
    send_main(b);
`endif
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_vbit(v[i]);
  endtask

  // Pulse so that the 3-bit instance samples counter[2:0] = v
  task automatic send3(input logic [2:0] v);
    logic [7:0] t;
    repeat (2) @(negedge clk);
    t = mcnt + 8'd2;
    while (t[2:0] != v) begin
      @(negedge clk);
      t = mcnt + 8'd2;
    end
    pulse3 = 1'b1;
    @(negedge clk);
    pulse3 = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
  endtask

  logic [2:0] v3 [8];
  logic [7:0] b3 [6];
  logic [7:0] pat;
  logic [7:0] exp1;
  logic       l0;
  int         t0;

  initial begin
    v3 = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd6, 3'd3, 3'd4, 3'd1};
    b3 = '{8'h3C, 8'hA5, 8'h0F, 8'hE7, 8'h99, 8'h42};

    // Reset held while the detector input toggles
    rst_n  = 1'b0;
    pulse  = 1'b0;
    pulse3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulse  = ~pulse;
      pulse3 = ~pulse3;
    end
    check_eq("rst_tx_data",  data,  0);
    check_eq("rst_valid",    valid, 0);
    check_eq("rst_level",    level, 0);
    check_eq("rst_overflow", ovf,   0);
    check_eq("rst_led",      led,   0);
    check_eq("rst3_valid_level_led", {valid3, level3, ovf3, led3, data3}, 0);
    pulse  = 1'b0;
    pulse3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("no_strobe_before_events", rx_q.size(), 0);

`ifndef VON_NEUMANN_EN
    // 3 bits per event: bits straddle byte boundaries
    for (int i = 0; i < 8; i++) send3(v3[i]);
    for (int i = 0; i < 60 && rx3_q.size() < 3; i++) @(negedge clk);
    check_eq("bpe3_count", rx3_q.size(), 3);
    check_eq("bpe3_byte0", rx3_q[0], 8'hAB);
    check_eq("bpe3_byte1", rx3_q[1], 8'h8C);
    check_eq("bpe3_byte2", rx3_q[2], 8'hE1);
    check_eq("bpe3_level", level3, 0);
`endif

    // One byte with a responsive uart_tx
    uart_mode = 0;
`ifdef VON_NEUMANN_EN
    pat = 8'b0110_1100;
    for (int r = 0; r < 4; r++)
      for (int i = 7; i >= 0; i--) send_main(pat[i]);
    exp1 = 8'h55;
`else
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) send_main(pat[i]);
    exp1 = 8'hB2;
`endif
    wait_rx(1, 40);
    check_eq("byte1_count", rx_q.size(), 1);
    check_eq("byte1_data",  rx_q[0], exp1);
    repeat (20) @(negedge clk);
    check_eq("byte1_held",   data,  exp1);
    check_eq("byte1_level",  level, 0);
    check_eq("byte1_led",    led,   0);
    check_eq("strobe_width", dbl,   0);

    // FIFO overflow with uart_tx stuck busy
    uart_mode = 2;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      send_byte(b3[k]);
      repeat (4) @(negedge clk);
      check_eq($sformatf("ovf_level_%0d", k), level, (k < 4) ? k + 1 : 4);
      check_eq($sformatf("ovf_flag_%0d", k),  ovf,   (k >= 4));
    end
    check_eq("ovf_no_strobe", rx_q.size(), 1);

    // Drain with uart_tx that never raises busy: timeout path
    uart_mode = 1;
    wait_rx(5, 100);
    check_eq("drain_count", rx_q.size(), 5);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("drain_byte_%0d", k), rx_q[k+1], b3[k]);
    for (int k = 1; k < 4; k++)
      check_eq($sformatf("drain_gap_%0d", k), rx_cyc[k+1] - rx_cyc[k], 6);
    check_eq("drain_level",  level, 0);
    check_eq("drain_sticky", ovf,   1);
    check_eq("drain_width",  dbl,   0);

    // Dead time: pulses every 5 cycles, only every fifth accepted
    uart_mode = 0;
    repeat (30) @(negedge clk);
    t0 = toggles;
    l0 = led;
    for (int i = 0; i < 10; i++) begin
      pulse = 1'b1;
      repeat (2) @(negedge clk);
      pulse = 1'b0;
      repeat (3) @(negedge clk);
      if (i == 0) check_eq("dt_first_led", led, !l0);
    end
    repeat (30) @(negedge clk);
    check_eq("dt_accepts", toggles - t0, 2);

    // Edge landing as the timer reaches zero is ignored
    t0 = toggles;
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    repeat (19) @(negedge clk);
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("dt_edge_at_zero", toggles - t0, 1);

    // One cycle later it is accepted
    t0 = toggles;
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    repeat (20) @(negedge clk);
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("dt_edge_after_zero", toggles - t0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_geiger_rng
`default_nettype wire

// File: doc/geiger_rng.md
Name: geiger_rng

Overview:
Parametrised successor of the single-pulse Geiger sampler. It synchronises the detector pulse, applies a dead-time filter, and samples the low bits of a free-running counter on each accepted event. Sampled bits are packed into bytes, buffered in a FIFO, and streamed to the existing uart_tx through its tx_data / tx_data_valid / transmitting handshake. Sits between the PMOD detector input and uart_tx at top level.

Parameters:
CNT_WIDTH, 8, width of free-running sample counter (>= BITS_PER_EVENT)
BITS_PER_EVENT, 1, counter LSBs harvested per accepted pulse (1..4)
FIFO_DEPTH, 16, byte FIFO entries (power of two, >= 2)
SYNC_STAGES, 2, flops in the pulse_in synchroniser (>= 2)
DEADTIME, 1000, clk cycles after an accepted edge during which further edges are ignored (0 = no filter)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pulse_in  in  1  raw asynchronous detector pulse
tx_busy  in  1  uart_tx transmitting flag
tx_data  out  8  byte to uart_tx
tx_data_valid  out  1  one-cycle send strobe to uart_tx
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a byte was dropped because FIFO full
event_led  out  1  toggles on every accepted event

Behaviour:
- Reset (async assert, sync release): counter, synchroniser, dead-time timer, bit assembler, FIFO pointers, FSM cleared; tx_data=0, tx_data_valid=0, fifo_level=0, overflow=0, event_led=0. Reset mid-transmission abandons the byte; uart_tx is not resynchronised.
- Counter: increments every cycle, wraps 2^CNT_WIDTH-1 -> 0.
- Edge detect: rising edge on last synchroniser stage; event latency SYNC_STAGES+1 cycles from pulse_in rise.
- Dead time: accepted edge loads timer with DEADTIME; edges while timer != 0 ignored; edge coinciding with timer reaching 0 is ignored; next cycle accepts.
- Harvest: accepted event shifts counter[BITS_PER_EVENT-1:0] into assembler, MSB-first, bit 0 of counter last. Bits straddling a byte boundary carry into the next byte. When 8 bits collected, byte is pushed the next cycle.
- FIFO: push accepted if level < FIFO_DEPTH or a pop occurs the same cycle; otherwise byte dropped, overflow set (cleared only by reset). Empty pop impossible (FSM gates it). Pointers wrap modulo FIFO_DEPTH.
- TX FSM: IDLE -> (fifo non-empty and tx_busy=0) ISSUE: tx_data=head, tx_data_valid=1 for exactly one cycle, pop head -> WAIT_BUSY until tx_busy=1 -> WAIT_DONE until tx_busy=0 -> IDLE. tx_data holds last byte until next ISSUE. WAIT_BUSY times out after 4 cycles back to IDLE (tolerates fast uart_tx).
- Minimum gap between strobes: 3 cycles.

Optional Feature:
VON_NEUMANN_EN: defined -> harvested bits consumed in pairs (first, second): 01 emits 0, 10 emits 1, 00/11 discarded; odd leftover bit held until next event. Undefined -> every harvested bit passed to assembler directly.

Decomposition:
- Package geiger_pkg: BYTE_W=8 constant, tx FSM state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE), WAIT_BUSY timeout constant.
- Sub-module rng_fifo: parametrised synchronous byte FIFO (push/pop/level/full/empty) with async active-low reset.

Test Plan:
- Reset with pulse_in toggling -> all outputs 0; no tx_data_valid until rst_n released and 8 events accepted.
- BITS_PER_EVENT=1, DEADTIME=0, 8 pulses timed so sampled LSBs are 1,0,1,1,0,0,1,0 -> one strobe with tx_data=8'hB2, tx_busy modelled high 10 cycles after strobe.
- DEADTIME=20, pulses 5 cycles apart x10 -> only 1 event in every 5 pulses accepted; event_led toggles accordingly.
- FIFO_DEPTH=4, tx_busy held 1, 6 bytes generated -> fifo_level saturates at 4, overflow=1, first 4 bytes later sent in order.
- tx_busy never asserts after strobe -> FSM returns to IDLE after 4 cycles and issues the next byte.
- VON_NEUMANN_EN defined, raw bits 0,1,1,0,1,1,0,0 repeated -> only 0,1 emitted per repeat; byte 8'h55 after 4 repeats.
